// File: rtl/tug_game_ctrl.sv
// Tug-of-war round/match sequencer: one rope-position register drives the LED bar,
// tracks round wins and sequences PLAY -> WIN -> PLAY/OVER. Optional CPU right player: TUG_CPU_OPPONENT_EN.
module tug_game_ctrl #(
   parameter int NUM_LIGHTS = 9,
   parameter int SCORE_MAX  = 7,
   parameter int WIN_HOLD   = 4,
   localparam int SW = $clog2(SCORE_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  l_press,
   input  logic                  r_press,
   input  logic [9:0]            cpu_level,
   output logic [NUM_LIGHTS-1:0] light_on,
   output logic [1:0]            winner,
   output logic [SW-1:0]         l_score,
   output logic [SW-1:0]         r_score,
   output logic                  game_over
);

   localparam int PW = $clog2(NUM_LIGHTS);
   localparam int HW = $clog2(WIN_HOLD + 1);
   localparam logic [PW-1:0] CENTRE    = PW'((NUM_LIGHTS - 1) / 2);
   localparam logic [PW-1:0] LAST      = PW'(NUM_LIGHTS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(WIN_HOLD - 1);
   localparam logic [SW-1:0] SMAX      = SW'(SCORE_MAX);

   typedef enum logic [1:0] {PLAY, WIN, OVER} state_t;

   state_t        state;
   logic [PW-1:0] pos;
   logic [HW-1:0] hold_cnt;
   logic          r_eff;
   logic          l_go;
   logic          r_go;

`ifdef TUG_CPU_OPPONENT_EN
   logic [9:0] lfsr;
   logic       unused_r_press;

   always_ff @(posedge clk) begin
      if (reset)
         lfsr <= 10'h001;
      else
         lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
   end

   // The LFSR never holds zero, so cpu_level=0 never presses.
   assign r_eff          = (state == PLAY) && (lfsr <= cpu_level);
   assign unused_r_press = r_press;
`else
   logic unused_cpu_level;

   assign r_eff            = r_press;
   assign unused_cpu_level = ^cpu_level;
`endif

   assign l_go = l_press & ~r_eff;
   assign r_go = r_eff & ~l_press;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= PLAY;
         pos      <= CENTRE;
         hold_cnt <= '0;
         l_score  <= '0;
         r_score  <= '0;
         winner   <= 2'b00;
      end else begin
         case (state)
            PLAY: begin
               if (l_go) begin
                  if (pos == LAST) begin
                     state    <= WIN;
                     winner   <= 2'b01;
                     l_score  <= l_score + SW'(1);
                     hold_cnt <= '0;
                  end else begin
                     pos <= pos + PW'(1);
                  end
               end else if (r_go) begin
                  if (pos == '0) begin
                     state    <= WIN;
                     winner   <= 2'b10;
                     r_score  <= r_score + SW'(1);
                     hold_cnt <= '0;
                  end else begin
                     pos <= pos - PW'(1);
                  end
               end
            end
            WIN: begin
               hold_cnt <= hold_cnt + HW'(1);
               if (hold_cnt == HOLD_LAST) begin
                  if (l_score == SMAX || r_score == SMAX) begin
                     state <= OVER;
                  end else begin
                     state  <= PLAY;
                     pos    <= CENTRE;
                     winner <= 2'b00;
                  end
               end
            end
            OVER: begin
            end
            default: state <= PLAY;
         endcase
      end
   end

   always_comb begin
      light_on = '0;
      if (state == PLAY)
         light_on = NUM_LIGHTS'(1) << pos;
   end

   assign game_over = (state == OVER);

endmodule

// File: tb/tb_tug_game_ctrl.sv
// Self-checking bench for tug_game_ctrl: directed scenarios plus random presses,
// every cycle compared against a rule-level model of the game.
module tb_tug_game_ctrl;

   localparam int N    = 9;
   localparam int SMAX = 7;
   localparam int HOLD = 4;
   localparam int SW   = $clog2(SMAX + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          l_press = 1'b0;
   logic          r_press = 1'b0;
   logic [9:0]    cpu_level = 10'd0;
   logic [N-1:0]  light_on;
   logic [1:0]    winner;
   logic [SW-1:0] l_score;
   logic [SW-1:0] r_score;
   logic          game_over;

   int n_tests = 0;
   int n_fail  = 0;

   // game model: rope index, scores, last winner, WIN cycles remaining, match over
   int m_pos, m_ls, m_rs, m_win, m_hold, m_lfsr;
   bit m_over;

   tug_game_ctrl #(.NUM_LIGHTS(N), .SCORE_MAX(SMAX), .WIN_HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .l_press(l_press), .r_press(r_press),
      .cpu_level(cpu_level), .light_on(light_on), .winner(winner),
      .l_score(l_score), .r_score(r_score), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit l, input bit r_in, input bit rs);
      bit r;
      r = r_in;
`ifdef TUG_CPU_OPPONENT_EN
      r = (!m_over && m_hold == 0 && m_lfsr <= int'(cpu_level));
      m_lfsr = ((m_lfsr << 1) & 'h3ff) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
`endif
      if (rs) begin
         m_pos = (N - 1) / 2; m_ls = 0; m_rs = 0; m_win = 0; m_hold = 0; m_over = 0;
         m_lfsr = 1;
      end else if (m_over) begin
      end else if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) begin
            if (m_ls == SMAX || m_rs == SMAX) m_over = 1;
            else begin m_pos = (N - 1) / 2; m_win = 0; end
         end
      end else if (l && !r) begin
         if (m_pos == N - 1) begin m_win = 1; m_ls++; m_hold = HOLD; end
         else m_pos++;
      end else if (r && !l) begin
         if (m_pos == 0) begin m_win = 2; m_rs++; m_hold = HOLD; end
         else m_pos--;
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] exp_light;
      exp_light = (m_hold == 0 && !m_over) ? (N'(1) << m_pos) : '0;
      chk("light_on", 16'(light_on), 16'(exp_light));
      chk("winner", 16'(winner), 16'(m_win));
      chk("l_score", 16'(l_score), 16'(m_ls));
      chk("r_score", 16'(r_score), 16'(m_rs));
      chk("game_over", 16'(game_over), 16'(m_over));
   endtask

   task automatic cycle(input bit l, input bit r, input bit rs);
      l_press = l; r_press = r; reset = rs;
      @(posedge clk);
      model_step(l, r, rs);
      #1;
      compare_all();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_light"}, 16'(light_on), 16'h0010);
      chk({tag, "_winner"}, 16'(winner), 16'h0);
      chk({tag, "_lscore"}, 16'(l_score), 16'h0);
      chk({tag, "_rscore"}, 16'(r_score), 16'h0);
      chk({tag, "_over"}, 16'(game_over), 16'h0);
   endtask

   initial begin
      int pl, pr;
`ifdef TUG_CPU_OPPONENT_EN
      cpu_level = 10'd1023;
      cycle(0, 0, 1);
      check_reset_state("cpu_reset");
      for (int i = 0; i < 4; i++) cycle(0, 0, 0);
      chk("cpu_max_before_win", 16'(winner), 16'h0);
      cycle(0, 0, 0);
      chk("cpu_max_win", 16'(winner), 16'h2);
      cpu_level = 10'd0;
      cycle(0, 0, 1);
      for (int i = 0; i < 1000; i++) cycle(0, $urandom_range(0, 1), 0);
      chk("cpu_zero_centre", 16'(light_on), 16'h0010);
      for (int i = 0; i < 1500; i++) begin
         if (i % 300 == 0) cpu_level = 10'($urandom_range(0, 1023));
         cycle($urandom_range(0, 99) < 40, 0, $urandom_range(0, 399) == 0);
      end
`else
      // reset state
      cycle(0, 0, 1);
      check_reset_state("reset");

      // left walks to the edge, then wins the round
      for (int i = 0; i < 4; i++) begin cycle(1, 0, 0); cycle(0, 0, 0); end
      chk("left_edge", 16'(light_on), 16'h0100);
      cycle(1, 0, 0);
      chk("left_win_winner", 16'(winner), 16'h1);
      chk("left_win_score", 16'(l_score), 16'h1);
      for (int i = 0; i < 3; i++) cycle(1, 1, 0);
      chk("win_dark", 16'(light_on), 16'h0);
      cycle(0, 0, 0);
      chk("next_round_light", 16'(light_on), 16'h0010);
      chk("next_round_winner", 16'(winner), 16'h0);

      // simultaneous presses hold; alternating returns to centre
      for (int i = 0; i < 3; i++) cycle(1, 1, 0);
      chk("both_hold", 16'(light_on), 16'h0010);
      for (int i = 0; i < 3; i++) begin cycle(1, 0, 0); cycle(0, 1, 0); end
      cycle(0, 1, 0); cycle(1, 0, 0);
      chk("alt_centre", 16'(light_on), 16'h0010);

      // right takes seven rounds and the match
      for (int rnd = 0; rnd < SMAX; rnd++) begin
         for (int i = 0; i < 5; i++) cycle(0, 1, 0);
         for (int i = 0; i < HOLD; i++) cycle(0, 0, 0);
      end
      chk("match_rscore", 16'(r_score), 16'h7);
      chk("match_winner", 16'(winner), 16'h2);
      chk("match_over", 16'(game_over), 16'h1);
      for (int i = 0; i < 12; i++) cycle($urandom_range(0, 1), $urandom_range(0, 1), 0);
      chk("over_frozen", 16'(r_score), 16'h7);

      // reset out of OVER, then reset in cycle 2 of WIN
      cycle(0, 0, 1);
      check_reset_state("reset_over");
      for (int i = 0; i < 5; i++) cycle(1, 0, 0);
      cycle(0, 0, 0);
      chk("mid_win_dark", 16'(light_on), 16'h0);
      cycle(0, 0, 1);
      check_reset_state("reset_win");

      // random play with occasional resets
      for (int seg = 0; seg < 12; seg++) begin
         pl = ($urandom_range(0, 2) == 1) ? 60 : 30;
         pr = ($urandom_range(0, 2) == 2) ? 60 : 30;
         for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < pl, $urandom_range(0, 99) < pr,
                  $urandom_range(0, 499) == 0);
      end
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
